// File: rtl/pmodda2_pkg.sv
// pmodda2_pkg
// Shared definitions for the PmodDA2 (DAC121S101-style) serial transmitter.
//   FRAME_W     : bits per serial frame (2 don't-care, 2 power-down, 12 data)
//   DATA_W      : sample width
//   pd_mode_e   : power-down codes carried in frame bits 13:12
//   state_e     : transmitter FSM states
//   build_frame : assembles the 16-bit frame, MSB first on the wire
package pmodda2_pkg;

  localparam int FRAME_W = 16;
  localparam int DATA_W  = 12;

  typedef enum logic [1:0] {
    NORMAL  = 2'b00,
    PD_1K   = 2'b01,
    PD_100K = 2'b10,
    PD_HIZ  = 2'b11
  } pd_mode_e;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_LO,
    SHIFT_HI,
    GAP
  } state_e;

  // The two leading don't-care bits are driven as zero.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [1:0]        pd,
                                                     input logic [DATA_W-1:0] d);
    return {2'b00, pd, d};
  endfunction

endpackage

// File: rtl/pmodda2_tx_clk_div.sv
// pmodda2_tx_clk_div
// Half-period tick generator for the DAC serial clock.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   clear : synchronous restart of the half-period count
//   tick  : high on the last system clock of a half-period
// The count runs 0..CLK_DIV-1; tick is asserted while the count sits at
// CLK_DIV-1, so a half-period starting from a clear lasts exactly CLK_DIV clks.
module pmodda2_tx_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running modulo-CLK_DIV counter, restarted whenever the FSM changes state.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/pmodda2_tx.sv
// pmodda2_tx
// Serial transmitter for a PmodDA2 / DAC121S101 converter (SCLK, SYNCn, DIN).
//   clk      : system clock, all logic on posedge
//   rst      : synchronous active-high reset
//   data_i   : 12-bit sample, taken when valid_i && ready_o
//   valid_i  : sample valid
//   ready_o  : high only while idle
//   done_o   : one-clk pulse as SYNCn rises at frame end
//   SCLK     : serial clock, idles high
//   SYNCn    : active-low frame enable
//   DIN      : serial data, stable around every SCLK falling edge
// Optional build macro PMODDA2_DUAL_CHANNEL_EN adds data_b_i / DINB, a second
// channel framed identically and shifted in lockstep with DIN.
// All outputs come straight from flops.
module pmodda2_tx
  import pmodda2_pkg::*;
#(
  parameter int         CLK_DIV    = 2,
  parameter int         GAP_CYCLES = 4,
  parameter logic [1:0] PD_MODE    = NORMAL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
`ifdef PMODDA2_DUAL_CHANNEL_EN
  input  logic [DATA_W-1:0] data_b_i,
  output logic              DINB,
`endif
  output logic              ready_o,
  output logic              done_o,
  output logic              SCLK,
  output logic              SYNCn,
  output logic              DIN
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  state_e state, state_n;

  logic               tick;
  logic               accept;
  logic               rise;
  logic [3:0]         bit_cnt;
  logic               last_bit;
  logic [GW-1:0]      gap_cnt;
  logic [FRAME_W-1:0] shift;
  logic               sclk_q, syncn_q, ready_q, done_q;
`ifdef PMODDA2_DUAL_CHANNEL_EN
  logic [FRAME_W-1:0] shift_b;
`endif

  assign accept = (state == IDLE) && valid_i && ready_q;
  assign rise   = (state == SHIFT_LO) && (state_n == SHIFT_HI);

  // Half-period timing restarts on every state entry so each phase is exactly CLK_DIV clks.
  pmodda2_tx_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk  (clk),
    .rst  (rst),
    .clear(state_n != state),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // last_bit is set on the 16th rising edge, so the following high phase ends the frame.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (accept) state_n = SETUP;
      SETUP:    if (tick) state_n = SHIFT_LO;
      SHIFT_LO: if (tick) state_n = SHIFT_HI;
      SHIFT_HI: if (tick) state_n = last_bit ? GAP : SHIFT_LO;
      GAP:      if (gap_cnt == GAP_LAST) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // The frame shifts on each SCLK rise; after the 16th rise the register is all
  // zeros, which leaves DIN low for the final high phase and the gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift    <= '0;
      bit_cnt  <= '0;
      last_bit <= 1'b0;
    end else if (accept) begin
      shift    <= build_frame(PD_MODE, data_i);
      bit_cnt  <= '0;
      last_bit <= 1'b0;
    end else if (rise) begin
      shift <= {shift[FRAME_W-2:0], 1'b0};
      if (bit_cnt == 4'd15) begin
        last_bit <= 1'b1;
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
      end
    end
  end

`ifdef PMODDA2_DUAL_CHANNEL_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_b <= '0;
    end else if (accept) begin
      shift_b <= build_frame(PD_MODE, data_b_i);
    end else if (rise) begin
      shift_b <= {shift_b[FRAME_W-2:0], 1'b0};
    end
  end

  assign DINB = shift_b[FRAME_W-1];
`endif

  always_ff @(posedge clk) begin
    if (rst || (state != GAP) || (state_n != GAP)) begin
      gap_cnt <= '0;
    end else begin
      gap_cnt <= gap_cnt + GW'(1);
    end
  end

  // Output flops are loaded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q  <= 1'b1;
      syncn_q <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      sclk_q  <= (state_n != SHIFT_LO);
      syncn_q <= !((state_n == SETUP) || (state_n == SHIFT_LO) || (state_n == SHIFT_HI));
      ready_q <= (state_n == IDLE);
      done_q  <= (state == SHIFT_HI) && (state_n == GAP);
    end
  end

  assign SCLK    = sclk_q;
  assign SYNCn   = syncn_q;
  assign ready_o = ready_q;
  assign done_o  = done_q;
  assign DIN     = shift[FRAME_W-1];

endmodule

// File: tb/tb_pmodda2_tx.sv
// tb_pmodda2_tx
// Drives pmodda2_tx (CLK_DIV=2, GAP_CYCLES=4) and a second instance with
// PD_MODE=01 on the same stimulus; event-driven DAC receivers decode the
// serial lines and results are compared to frames computed from sample values.
// Build with PMODDA2_DUAL_CHANNEL_EN defined to also check DINB.
module tb_pmodda2_tx;

  localparam int CLK_DIV    = 2;
  localparam int GAP_CYCLES = 4;
  localparam int LOW_CLKS   = CLK_DIV * 33;
  localparam int BUSY_CLKS  = LOW_CLKS + GAP_CYCLES;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic [11:0] data_i = '0;
  logic        ready_o, done_o, SCLK, SYNCn, DIN;
  logic        ready_p, done_p, sclk_p, syncn_p, din_p;
`ifdef PMODDA2_DUAL_CHANNEL_EN
  logic [11:0] data_b_i = '0;
  logic        DINB, dinb_p;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int din_viol = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pmodda2_tx #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES), .PD_MODE(2'b00)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i),
`ifdef PMODDA2_DUAL_CHANNEL_EN
    .data_b_i(data_b_i), .DINB(DINB),
`endif
    .ready_o(ready_o), .done_o(done_o), .SCLK(SCLK), .SYNCn(SYNCn), .DIN(DIN)
  );

  pmodda2_tx #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES), .PD_MODE(2'b01)) dut_pd (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i),
`ifdef PMODDA2_DUAL_CHANNEL_EN
    .data_b_i(data_b_i), .DINB(dinb_p),
`endif
    .ready_o(ready_p), .done_o(done_p), .SCLK(sclk_p), .SYNCn(syncn_p), .DIN(din_p)
  );

  // Reference frame: two zero bits, power-down code, then the sample.
  function automatic logic [15:0] model_frame(input int pd, input int d);
    return 16'((pd * 4096) + d);
  endfunction

  // DAC receiver: shifts DIN on SCLK falls while SYNCn is low and accepts
  // the frame on SYNCn rise only if exactly 16 bits arrived.
  logic [15:0] rx_sh = '0, rx_frame = '0, rxb_sh = '0, rxb_frame = '0;
  logic [15:0] rxp_sh = '0, rxp_frame = '0;
  logic [11:0] vout = '0;
  int rx_fall = 0, rx_rise = 0, last_fall = 0, last_rise = 0, frames = 0;
  logic prev_sclk = 1'b1, prev_sync = 1'b1;

  always @(SCLK or SYNCn) begin
    if (prev_sync === 1'b1 && SYNCn === 1'b0) begin
      rx_fall = 0;
      rx_rise = 0;
    end
    if (SYNCn === 1'b0) begin
      if (prev_sclk === 1'b1 && SCLK === 1'b0) begin
        rx_sh = {rx_sh[14:0], DIN};
`ifdef PMODDA2_DUAL_CHANNEL_EN
        rxb_sh = {rxb_sh[14:0], DINB};
`endif
        rx_fall++;
      end
      if (prev_sclk === 1'b0 && SCLK === 1'b1) rx_rise++;
    end
    if (prev_sync === 1'b0 && SYNCn === 1'b1) begin
      last_fall = rx_fall;
      last_rise = rx_rise;
      if (rx_fall == 16) begin
        rx_frame  = rx_sh;
        rxb_frame = rxb_sh;
        vout      = rx_sh[11:0];
        frames++;
      end
    end
    prev_sclk = SCLK;
    prev_sync = SYNCn;
  end

  logic pp_sclk = 1'b1, pp_sync = 1'b1;
  always @(sclk_p or syncn_p) begin
    if (syncn_p === 1'b0 && pp_sclk === 1'b1 && sclk_p === 1'b0) rxp_sh = {rxp_sh[14:0], din_p};
    if (pp_sync === 1'b0 && syncn_p === 1'b1) rxp_frame = rxp_sh;
    pp_sclk = sclk_p;
    pp_sync = syncn_p;
  end

  // DIN may only change together with an SCLK rise while a frame is active.
  logic pdin = 1'b0, psclk = 1'b1, psync = 1'b1;
  always @(negedge clk) begin
    if (!rst && SYNCn === 1'b0 && psync === 1'b0 && DIN !== pdin &&
        !(SCLK === 1'b1 && psclk === 1'b0))
      din_viol <= din_viol + 1;
    pdin  <= DIN;
    psclk <= SCLK;
    psync <= SYNCn;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog");
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ready_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic start_frame(input logic [11:0] d, output bit ok);
    wait_ready(ok);
    data_i  = d;
    valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  // Samples each negedge until ready_o returns; reports busy/low lengths.
  task automatic watch_frame(output int rdy_low, output int sync_low, output int dones,
                             output int first_low_at, output int rise_at, output bit ok);
    rdy_low = 0; sync_low = 0; dones = 0; first_low_at = -1; rise_at = -1; ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (ready_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      rdy_low++;
      if (SYNCn === 1'b0) begin
        sync_low++;
        if (first_low_at < 0) first_low_at = cyc;
      end else if (rise_at < 0 && sync_low > 0) begin
        rise_at = cyc;
      end
      if (done_o === 1'b1) dones++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b1; data_i = 12'h7E7;
    repeat (3) @(negedge clk);
    checks++; if (SCLK !== 1'b1) begin errors++; $display("[TB] FAIL reset_sclk: got %b want 1", SCLK); end
    checks++; if (SYNCn !== 1'b1) begin errors++; $display("[TB] FAIL reset_syncn: got %b want 1", SYNCn); end
    checks++; if (DIN !== 1'b0) begin errors++; $display("[TB] FAIL reset_din: got %b want 0", DIN); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b want 1", ready_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", done_o); end
    rst = 1'b0; valid_i = 1'b0;
    @(negedge clk);
    checks++; if (SYNCn !== 1'b1 || ready_o !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_valid_ignored: syncn=%b ready=%b want 1 1", SYNCn, ready_o);
    end
  endtask

  task automatic test_single();
    bit ok, ok2; int rl, sl, dn, fl, ra, f0;
    f0 = frames;
`ifdef PMODDA2_DUAL_CHANNEL_EN
    data_b_i = 12'h0F0;
`endif
    start_frame(12'hA5C, ok);
    watch_frame(rl, sl, dn, fl, ra, ok2);
    checks++; if (!(ok && ok2)) begin errors++; $display("[TB] FAIL single_timeout: got ok=%b/%b want 1/1", ok, ok2); end
    checks++; if (rx_frame !== model_frame(0, 'hA5C)) begin errors++; $display("[TB] FAIL single_frame: got %h want %h", rx_frame, model_frame(0, 'hA5C)); end
    checks++; if (sl != LOW_CLKS) begin errors++; $display("[TB] FAIL single_sync_low: got %0d want %0d", sl, LOW_CLKS); end
    checks++; if (dn != 1) begin errors++; $display("[TB] FAIL single_done_pulses: got %0d want 1", dn); end
    checks++; if (rl != BUSY_CLKS) begin errors++; $display("[TB] FAIL single_ready_low: got %0d want %0d", rl, BUSY_CLKS); end
    checks++; if (vout !== 12'hA5C) begin errors++; $display("[TB] FAIL single_vout: got %h want a5c", vout); end
    checks++; if (frames != f0 + 1) begin errors++; $display("[TB] FAIL single_frames: got %0d want %0d", frames, f0 + 1); end
    checks++; if (last_fall != 16 || last_rise != 16) begin
      errors++; $display("[TB] FAIL single_edges: got fall=%0d rise=%0d want 16 16", last_fall, last_rise);
    end
    checks++; if (din_viol != 0) begin errors++; $display("[TB] FAIL single_din_stable: got %0d changes want 0", din_viol); end
    checks++; if (rxp_frame !== model_frame(1, 'hA5C)) begin errors++; $display("[TB] FAIL pd_mode_frame: got %h want %h", rxp_frame, model_frame(1, 'hA5C)); end
`ifdef PMODDA2_DUAL_CHANNEL_EN
    checks++; if (rxb_frame !== model_frame(0, 'h0F0)) begin errors++; $display("[TB] FAIL dual_frame: got %h want %h", rxb_frame, model_frame(0, 'h0F0)); end
`endif
  endtask

  task automatic test_back_to_back();
    bit ok, ok1, ok2; int rl1, sl1, dn1, fl1, ra1, rl2, sl2, dn2, fl2, ra2, f0;
    logic [11:0] v1;
    f0 = frames;
    wait_ready(ok);
    data_i = 12'h000; valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data_i = 12'hFFF;
    watch_frame(rl1, sl1, dn1, fl1, ra1, ok1);
    v1 = vout;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    watch_frame(rl2, sl2, dn2, fl2, ra2, ok2);
    checks++; if (!(ok && ok1 && ok2)) begin errors++; $display("[TB] FAIL b2b_timeout: got ok=%b%b%b want 111", ok, ok1, ok2); end
    checks++; if (v1 !== 12'h000) begin errors++; $display("[TB] FAIL b2b_first_vout: got %h want 000", v1); end
    checks++; if (rl1 != BUSY_CLKS || rl2 != BUSY_CLKS) begin
      errors++; $display("[TB] FAIL b2b_ready_low: got %0d/%0d want %0d", rl1, rl2, BUSY_CLKS);
    end
    checks++; if (fl2 - ra1 != GAP_CYCLES + 1) begin errors++; $display("[TB] FAIL b2b_gap: got %0d want %0d", fl2 - ra1, GAP_CYCLES + 1); end
    checks++; if (vout !== 12'hFFF) begin errors++; $display("[TB] FAIL b2b_vout: got %h want fff", vout); end
    checks++; if (frames != f0 + 2) begin errors++; $display("[TB] FAIL b2b_frames: got %0d want %0d", frames, f0 + 2); end
  endtask

  task automatic test_ignore_midframe();
    bit ok, ok2; int rl, sl, dn, fl, ra, f0, bad;
    f0 = frames;
    start_frame(12'h3C3, ok);
    for (int i = 0; i < 20; i++) begin
      data_i  = 12'h123;
      valid_i = i[0];
      @(negedge clk);
    end
    valid_i = 1'b0;
    watch_frame(rl, sl, dn, fl, ra, ok2);
    checks++; if (!(ok && ok2)) begin errors++; $display("[TB] FAIL ignore_timeout: got ok=%b/%b want 1/1", ok, ok2); end
    checks++; if (vout !== 12'h3C3) begin errors++; $display("[TB] FAIL ignore_vout: got %h want 3c3", vout); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (SYNCn !== 1'b1 || ready_o !== 1'b1) bad++;
      @(negedge clk);
    end
    checks++; if (bad != 0 || frames != f0 + 1) begin
      errors++; $display("[TB] FAIL ignore_extra_transfer: got busy=%0d frames=%0d want 0 %0d", bad, frames, f0 + 1);
    end
  endtask

  task automatic test_reset_midframe();
    bit ok, ok2, hit; int rl, sl, dn, fl, ra, f0, dones;
    logic [11:0] prev;
    prev = vout; f0 = frames; hit = 1'b0;
    start_frame(12'h9E1, ok);
    for (int i = 0; i < 200; i++) begin
      if (rx_fall >= 7) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++; if (!(ok && hit)) begin errors++; $display("[TB] FAIL rstmid_timeout: got ok=%b hit=%b want 1 1", ok, hit); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (SYNCn !== 1'b1 || SCLK !== 1'b1) begin
      errors++; $display("[TB] FAIL rstmid_lines: got syncn=%b sclk=%b want 1 1", SYNCn, SCLK);
    end
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (done_o !== 1'b0) dones++;
      @(negedge clk);
    end
    checks++; if (dones != 0) begin errors++; $display("[TB] FAIL rstmid_done: got %0d pulses want 0", dones); end
    checks++; if (vout !== prev || frames != f0) begin
      errors++; $display("[TB] FAIL rstmid_vout_held: got %h/%0d want %h/%0d", vout, frames, prev, f0);
    end
    start_frame(12'h456, ok);
    watch_frame(rl, sl, dn, fl, ra, ok2);
    checks++; if (vout !== 12'h456 || !ok2) begin errors++; $display("[TB] FAIL rstmid_next_vout: got %h want 456", vout); end
  endtask

  task automatic test_random();
    bit ok, ok2; int rl, sl, dn, fl, ra; int d;
    for (int n = 0; n < 5; n++) begin
      d = int'($urandom_range(0, 4095));
`ifdef PMODDA2_DUAL_CHANNEL_EN
      data_b_i = 12'($urandom_range(0, 4095));
`endif
      start_frame(12'(d), ok);
      watch_frame(rl, sl, dn, fl, ra, ok2);
      checks++; if (rx_frame !== model_frame(0, d) || !(ok && ok2)) begin
        errors++; $display("[TB] FAIL rand_frame_%0d: got %h want %h", n, rx_frame, model_frame(0, d));
      end
      checks++; if (rxp_frame !== model_frame(1, d)) begin
        errors++; $display("[TB] FAIL rand_pd_frame_%0d: got %h want %h", n, rxp_frame, model_frame(1, d));
      end
`ifdef PMODDA2_DUAL_CHANNEL_EN
      checks++; if (rxb_frame !== model_frame(0, int'(data_b_i))) begin
        errors++; $display("[TB] FAIL rand_dual_%0d: got %h want %h", n, rxb_frame, model_frame(0, int'(data_b_i)));
      end
`endif
    end
    checks++; if (din_viol != 0) begin errors++; $display("[TB] FAIL din_stable_total: got %0d changes want 0", din_viol); end
  endtask

  initial begin
    $display("[TB] pmodda2_tx bench start");
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_midframe();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
